hex_display_ctrl: RTL and testbench
===================================

// Module: hex_display_ctrl
// PURPOSE
//  Sequencer for the DE10-Lite HEX0..HEX5 seven-segment bank.
//  - Accepts a packed multi-digit hex value over a valid/ready handshake.
//  - Time-shares ONE seven_segment decoder instance, one digit per clock, to refresh per-digit
//    output registers. Adds leading-zero blanking, per-digit decimal points and per-digit blink.
//  - Sits between game/VGA logic (score, debug values) and the HEX pins.
// PARAMETERS
//  NUM_DIGITS   6           number of digits (1..8)
//  BLINK_DIV    25_000_000  clocks per blink half-period (>=2); 0.5 s at 50 MHz
// PORTS
//  clk           in   1              system clock
//  reset         in   1              synchronous, active-high reset
//  wr_valid      in   1              requester has a new value
//  wr_ready      out  1              block can accept (high only in IDLE)
//  wr_value      in   4*NUM_DIGITS   nibble i = digit i; digit 0 = rightmost
//  wr_dp         in   NUM_DIGITS     1 = decimal point lit on digit i
//  blank_lz      in   1              1 = blank leading zeros; sampled at accept
//  blink_en      in   NUM_DIGITS     1 = digit i blinks; live input, not captured
//  hex_out       out  8*NUM_DIGITS   byte i to HEXi; active-low; bit0=a..bit6=g, bit7=DP
//  busy          out  1              1 while a refresh is in progress
//  refresh_done  out  1              one-cycle pulse when all digits are updated
// BEHAVIOUR
//  Clock and reset
//  - One clock domain. reset is synchronous and active-high. No asynchronous reset anywhere.
//  Reset values (applied on the clk edge where reset=1)
//  - State = IDLE; all digit registers = 8'hFF (all segments off).
//  - Blink counter = 0; blink phase = 0.
//  - busy = 0, refresh_done = 0, wr_ready = 1.
//  - A reset during SCAN aborts the scan and discards the captured value.
//  FSM states: IDLE -> SCAN -> DONE -> IDLE
//  - IDLE:
//    - wr_ready = 1.
//    - When wr_valid=1: capture wr_value, wr_dp and blank_lz into shadow registers,
//      set idx = NUM_DIGITS-1, set lz_run = 1, go to SCAN.
//    - wr_valid=0: stay in IDLE.
//  - SCAN:
//    - wr_ready = 0, busy = 1. wr_valid is ignored; the requester holds its value until accepted.
//    - Each cycle the shared decoder receives shadow nibble[idx].
//    - On the clk edge, digit register[idx] is written as follows:
//      - seg[6:0] = 7'h7F if blanked, else decoder[6:0].
//      - seg[7] = ~shadow_dp[idx]. Decoder bit7 is always discarded.
//      - The digit is blanked when blank_lz=1, lz_run=1, nibble==0 and idx!=0.
//        Digit 0 is never blanked.
//      - lz_run is cleared by the first nonzero nibble.
//    - idx decrements each cycle. After the idx=0 write, go to DONE.
//  - DONE:
//    - refresh_done = 1 for exactly one cycle, busy = 1, wr_ready = 0.
//    - Go to IDLE on the next edge.
//  Timing
//  - Handshake at edge T. Digit NUM_DIGITS-1 updates at T+1; digit 0 updates at T+NUM_DIGITS.
//  - refresh_done is high during the cycle after edge T+NUM_DIGITS.
//  - wr_ready is high again after edge T+NUM_DIGITS+1.
//  - Minimum accept spacing is NUM_DIGITS+2 cycles.
//  - Digits not yet rewritten keep their old value (no intermediate blanking).
//  Blink
//  - Free-running counter 0..BLINK_DIV-1. Blink phase toggles on the wrap edge.
//  - Counter and phase run independently of the FSM.
//  - hex_out byte i is combinational: 8'hFF when blink_en[i] && phase, else digit register[i].
//    DP is also blanked in the off phase.
// TESTING
//  1. Assert reset for 2 cycles, then release
//     -> every hex_out byte = FF; wr_ready=1; busy=0; refresh_done=0.
//  2. value=24'h012345, dp=0, blank_lz=0, accepted at edge T
//     -> digits 5..0 = C0,F9,A4,B0,99,92 after T+6; busy high T+1..T+7; one refresh_done pulse.
//  3. blank_lz=1, value=24'h000A05
//     -> digits 5..0 = FF,FF,FF,88,C0,92 (interior zero kept).
//     value=0 -> digits 5..1 = FF, digit 0 = C0.
//  4. value=24'h000008, wr_dp=6'b000001 -> digit0 = 00; digit1 (blank_lz=0) = C0.
//     Same value, blank_lz=1 -> digit1 = 7F... no: DP is off, so digit1 = FF.
//  5. wr_valid held high while the value changes every cycle
//     -> accepts exactly every 8 cycles, each accept captures the value present that cycle;
//     wr_ready=0 throughout SCAN and DONE.
//  6. BLINK_DIV=4, blink_en=6'b000001
//     -> digit0 alternates data/FF every 4 cycles; other digits stay steady.
//     Reset asserted after the 3rd SCAN write -> all bytes FF, IDLE and wr_ready=1 next cycle.

Source files
------------

// File: rtl/hex_display_ctrl_if.sv
// Write-side handshake for hex_display_ctrl: one packed hex value plus its
// decimal-point mask and leading-zero-blank flag.
interface hex_display_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [4*NUM_DIGITS-1:0] wr_value;
    logic [NUM_DIGITS-1:0]   wr_dp;
    logic                    blank_lz;

    modport master (output wr_valid, wr_value, wr_dp, blank_lz, input wr_ready);
    modport slave  (input wr_valid, wr_value, wr_dp, blank_lz, output wr_ready);
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment bank sequencer: one shared decoder refreshes one digit per clock,
// with leading-zero blanking, per-digit DP and a free-running blink overlay.
module seven_segment (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    // Active-low segments, bit0=a .. bit6=g
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_display_ctrl_if.slave       wr,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [8*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    refresh_done
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e state_q, state_d;

    logic [NUM_DIGITS-1:0][3:0] nib_q, nib_d;
    logic [NUM_DIGITS-1:0]      dp_q, dp_d;
    logic                       blz_q, blz_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       lz_run_q, lz_run_d;
    logic [NUM_DIGITS-1:0][7:0] digit_q, digit_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       phase_q, phase_d;

    logic       accept, scan_we, blank;
    logic [3:0] cur_nib;
    logic [6:0] dec_seg;

    assign cur_nib = nib_q[idx_q];

    seven_segment u_dec (.nibble(cur_nib), .seg(dec_seg));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            nib_q    <= '0;
            dp_q     <= '0;
            blz_q    <= 1'b0;
            idx_q    <= '0;
            lz_run_q <= 1'b0;
            digit_q  <= '1;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            nib_q    <= nib_d;
            dp_q     <= dp_d;
            blz_q    <= blz_d;
            idx_q    <= idx_d;
            lz_run_q <= lz_run_d;
            digit_q  <= digit_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr.wr_valid) state_d = SCAN;
            SCAN:    if (idx_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr.wr_ready  = (state_q == IDLE);
        busy         = (state_q != IDLE);
        refresh_done = (state_q == DONE);
        accept       = (state_q == IDLE) && wr.wr_valid;
        scan_we      = (state_q == SCAN);
    end

    // Digit 0 always shows, so a zero value still reads "0"
    assign blank = blz_q && lz_run_q && (cur_nib == 4'h0) && (idx_q != '0);

    always_comb begin
        nib_d    = nib_q;
        dp_d     = dp_q;
        blz_d    = blz_q;
        idx_d    = idx_q;
        lz_run_d = lz_run_q;
        digit_d  = digit_q;
        if (accept) begin
            nib_d    = wr.wr_value;
            dp_d     = wr.wr_dp;
            blz_d    = wr.blank_lz;
            idx_d    = IDX_W'(NUM_DIGITS - 1);
            lz_run_d = 1'b1;
        end
        if (scan_we) begin
            digit_d[idx_q] = {~dp_q[idx_q], blank ? 7'h7F : dec_seg};
            idx_d          = idx_q - 1'b1;
            lz_run_d       = lz_run_q && (cur_nib == 4'h0);
        end
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_out
        assign hex_out[8*i +: 8] = (blink_en[i] && phase_q) ? 8'hFF : digit_q[i];
    end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: handshake timing, decode/blanking, DP, blink, reset abort.
module tb_hex_display_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  blink_en;
    logic [47:0] hex_out;
    logic        busy, refresh_done;
    logic [47:0] cur;
    int          checks = 0;
    int          errors = 0;

    hex_display_ctrl_if #(.NUM_DIGITS(6)) wr_if ();

    hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset), .wr(wr_if), .blink_en(blink_en),
        .hex_out(hex_out), .busy(busy), .refresh_done(refresh_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction from IDLE; exp is the image expected once all digits are rewritten
    task automatic send(input logic [23:0] v, input logic [5:0] dp, input logic blz,
                        input logic [47:0] exp);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_value = v;
        wr_if.wr_dp    = dp;
        wr_if.blank_lz = blz;
        chk("ready_idle", 48'(wr_if.wr_ready), 48'd1);
        step();
        wr_if.wr_valid = 1'b0;
        chk("busy_scan", 48'(busy), 48'd1);
        chk("ready_scan", 48'(wr_if.wr_ready), 48'd0);
        step();
        chk("digit5_first", 48'(hex_out[47:40]), 48'(exp[47:40]));
        chk("digit0_old", 48'(hex_out[7:0]), 48'(cur[7:0]));
        repeat (5) step();
        chk("done_pulse", 48'(refresh_done), 48'd1);
        chk("busy_done", 48'(busy), 48'd1);
        chk("image", hex_out, exp);
        step();
        chk("done_clear", 48'(refresh_done), 48'd0);
        chk("busy_clear", 48'(busy), 48'd0);
        chk("ready_back", 48'(wr_if.wr_ready), 48'd1);
        cur = exp;
    endtask

    initial begin
        bit found;
        reset          = 1'b1;
        blink_en       = '0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_value = '0;
        wr_if.wr_dp    = '0;
        wr_if.blank_lz = 1'b0;
        cur            = '1;

        repeat (2) step();
        reset = 1'b0;
        chk("rst_hex", hex_out, {6{8'hFF}});
        chk("rst_ready", 48'(wr_if.wr_ready), 48'd1);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_done", 48'(refresh_done), 48'd0);
        step();

        send(24'h012345, 6'b0, 1'b0, 48'hC0F9A4B09992);
        send(24'h000A05, 6'b0, 1'b1, 48'hFFFFFF88C092);
        send(24'h000000, 6'b0, 1'b1, 48'hFFFFFFFFFFC0);
        send(24'h000008, 6'b000001, 1'b0, 48'hC0C0C0C0C000);
        send(24'h000008, 6'b000001, 1'b1, 48'hFFFFFFFFFF00);

        // Held valid with a changing value: accepts land on k = 0, 8, 16
        wr_if.wr_valid = 1'b1;
        wr_if.wr_dp    = '0;
        wr_if.blank_lz = 1'b0;
        for (int k = 0; k < 24; k++) begin
            wr_if.wr_value = 24'h100000 + 24'(k);
            chk($sformatf("ready_k%0d", k), 48'(wr_if.wr_ready), 48'((k % 8) == 0));
            step();
        end
        wr_if.wr_valid = 1'b0;
        cur = 48'hF9C0C0C0F9C0;
        chk("held_image", hex_out, cur);

        // Blink on digit 0: sync to an off-phase start, then check a full period
        blink_en = 6'b000001;
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
            if (hex_out[7:0] == cur[7:0]) found = 1'b1;
            else step();
        end
        chk("blink_sync_on", 48'(found), 48'd1);
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
            if (hex_out[7:0] == 8'hFF) found = 1'b1;
            else step();
        end
        chk("blink_sync_off", 48'(found), 48'd1);
        for (int j = 1; j <= 8; j++) begin
            step();
            chk($sformatf("blink_d0_%0d", j), 48'(hex_out[7:0]),
                48'((j < 4 || j == 8) ? 8'hFF : cur[7:0]));
            chk($sformatf("blink_steady_%0d", j), 48'(hex_out[47:8]), 48'(cur[47:8]));
        end
        blink_en = '0;

        // Reset after the third scan write aborts the refresh
        wr_if.wr_valid = 1'b1;
        wr_if.wr_value = 24'h123456;
        step();
        wr_if.wr_valid = 1'b0;
        repeat (3) step();
        chk("partial_new", 48'(hex_out[47:24]), 48'hF9A4B0);
        chk("partial_old", 48'(hex_out[23:0]), 48'(cur[23:0]));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_hex", hex_out, {6{8'hFF}});
        chk("abort_ready", 48'(wr_if.wr_ready), 48'd1);
        chk("abort_busy", 48'(busy), 48'd0);
        repeat (8) step();
        chk("abort_discard", hex_out, {6{8'hFF}});
        chk("abort_idle", 48'(busy), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
